// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA axis timing types, standard modes and helpers
//
// Purpose: one axis (horizontal or vertical) is described by four segment
// lengths. Standard 640x480@60 and 800x600@60 modes are provided, together
// with axis_total(), which returns the full period of an axis.
package vga_timing_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] front_porch;
    logic [15:0] sync_pulse;
    logic [15:0] back_porch;
  } vga_axis_t;

  localparam vga_axis_t VGA_640x480_H = '{active: 16'd640, front_porch: 16'd16,
                                         sync_pulse: 16'd96, back_porch: 16'd48};
  localparam vga_axis_t VGA_640x480_V = '{active: 16'd480, front_porch: 16'd10,
                                         sync_pulse: 16'd2,  back_porch: 16'd33};
  localparam vga_axis_t VGA_800x600_H = '{active: 16'd800, front_porch: 16'd40,
                                         sync_pulse: 16'd128, back_porch: 16'd88};
  localparam vga_axis_t VGA_800x600_V = '{active: 16'd600, front_porch: 16'd1,
                                         sync_pulse: 16'd4,   back_porch: 16'd23};

  function automatic int axis_total(vga_axis_t a);
    return int'(a.active) + int'(a.front_porch) + int'(a.sync_pulse) + int'(a.back_porch);
  endfunction

endpackage

// File: rtl/vga_timing_generator_axis.sv
// rtl/vga_timing_generator_axis.sv - single-axis VGA counter with registered sync/active decode
//
// Module vga_axis_counter.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   step        : advance the counter by one position on this clk edge
//   count [CW]  : current position, resets to TOTAL-1 so the first step lands on 0
//   sync        : sync level (POLARITY while in the pulse, ~POLARITY otherwise)
//   active      : 1 while count < ACTIVE
//   wrap        : combinational, 1 while count == TOTAL-1 (next step returns to 0)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CW       = 12,
  parameter int ACTIVE   = 640,
  parameter int FP       = 16,
  parameter int SYNC     = 96,
  parameter int BP       = 48,
  parameter bit POLARITY = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          active,
  output logic          wrap
);

  localparam vga_axis_t CFG = '{active: 16'(ACTIVE), front_porch: 16'(FP),
                                sync_pulse: 16'(SYNC), back_porch: 16'(BP)};
  localparam int TOTAL = axis_total(CFG);
  localparam int SS    = ACTIVE + FP;
  localparam int SE    = SS + SYNC;

  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
  // One extra bit so the constants compare cleanly even when TOTAL == 2**CW.
  localparam logic [CW:0]   ACT_W = (CW+1)'(ACTIVE);
  localparam logic [CW:0]   SS_W  = (CW+1)'(SS);
  localparam logic [CW:0]   SE_W  = (CW+1)'(SE);

  if (TOTAL > (2 ** CW)) begin : g_total_chk
    $error("vga_axis_counter: total %0d does not fit in CW=%0d bits", TOTAL, CW);
  end
  if ((ACTIVE < 1) || (FP < 1) || (SYNC < 1) || (BP < 1)) begin : g_param_chk
    $error("vga_axis_counter: every segment length must be at least 1");
  end

  logic [CW-1:0] count_next;
  logic [CW:0]   next_w;

  assign wrap       = (count == LAST);
  assign count_next = wrap ? '0 : count + 1'b1;
  assign next_w     = {1'b0, count_next};

  // Decode from count_next so sync/active line up with count in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= LAST;
      sync   <= ~POLARITY;
      active <= 1'b0;
    end else if (step) begin
      count  <= count_next;
      sync   <= ((next_w >= SS_W) && (next_w < SE_W)) ? POLARITY : ~POLARITY;
      active <= (next_w < ACT_W);
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - full-frame VGA timing source (h/v counters, syncs, de, strobes)
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset (wins over pix_en)
//   pix_en          : pixel tick, counters advance only when 1
//   h_count, v_count: current pixel column / line
//   hsync, vsync    : sync outputs, polarity set by H_POLARITY / V_POLARITY
//   de              : display enable (inside the active area of both axes)
//   line_start      : one-clk strobe after the pix_en edge that loads h = 0
//   frame_start     : one-clk strobe after the pix_en edge that loads (0,0)
// Optional (macro VGA_TIMING_LINE_MATCH_EN):
//   line_match [CW] : line number to match, sampled on the pix_en edge
//   line_irq        : strobe coincident with line_start when new v_count == line_match
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int CW            = 12,
  parameter int H_ACTIVE      = int'(VGA_640x480_H.active),
  parameter int H_FRONT_PORCH = int'(VGA_640x480_H.front_porch),
  parameter int H_SYNC_PULSE  = int'(VGA_640x480_H.sync_pulse),
  parameter int H_BACK_PORCH  = int'(VGA_640x480_H.back_porch),
  parameter int V_ACTIVE      = int'(VGA_640x480_V.active),
  parameter int V_FRONT_PORCH = int'(VGA_640x480_V.front_porch),
  parameter int V_SYNC_PULSE  = int'(VGA_640x480_V.sync_pulse),
  parameter int V_BACK_PORCH  = int'(VGA_640x480_V.back_porch),
  parameter bit H_POLARITY    = 1'b0,
  parameter bit V_POLARITY    = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
`ifdef VGA_TIMING_LINE_MATCH_EN
  input  logic [CW-1:0] line_match,
  output logic          line_irq,
`endif
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  logic h_active, v_active;
  logic h_wrap, v_wrap;
  logic v_step;

  assign v_step = h_wrap & pix_en;

  vga_axis_counter #(
    .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FRONT_PORCH), .SYNC(H_SYNC_PULSE),
    .BP(H_BACK_PORCH), .POLARITY(H_POLARITY)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .step(pix_en),
    .count(h_count), .sync(hsync), .active(h_active), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FRONT_PORCH), .SYNC(V_SYNC_PULSE),
    .BP(V_BACK_PORCH), .POLARITY(V_POLARITY)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .step(v_step),
    .count(v_count), .sync(vsync), .active(v_active), .wrap(v_wrap)
  );

  // Both operands are registers updated on the same edge, so de changes
  // exactly with the counters.
  assign de = h_active & v_active;

  // The counters reset to the last position, so the wrap flags are already
  // set and the first pix_en after reset raises both strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en & h_wrap;
      frame_start <= pix_en & h_wrap & v_wrap;
    end
  end

`ifdef VGA_TIMING_LINE_MATCH_EN
  logic [CW-1:0] v_next_line;

  // Line about to be entered when h wraps; values >= V_TOTAL never match.
  assign v_next_line = v_wrap ? '0 : v_count + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_irq <= 1'b0;
    end else begin
      line_irq <= pix_en & h_wrap & (v_next_line == line_match);
    end
  end
`endif

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Full-frame VGA timing source: horizontal and vertical counters, hsync/vsync with per-axis polarity, display enable, and line/frame start strobes.
- Generalises the standalone horizontal sync decoder: both axes, counters owned internally, pixel-clock-enable gating, all outputs registered.
- Sits between the system clock domain and the pixel pipeline (framebuffer read, Game-of-Life renderer).

Parameters:
- CW, 12, width of the h and v counters.
- H_ACTIVE, 640, visible pixels per line.
- H_FRONT_PORCH, 16, pixels.
- H_SYNC_PULSE, 96, pixels.
- H_BACK_PORCH, 48, pixels.
- V_ACTIVE, 480, visible lines.
- V_FRONT_PORCH, 10, lines.
- V_SYNC_PULSE, 2, lines.
- V_BACK_PORCH, 33, lines.
- H_POLARITY, 0, 0 = hsync low during the pulse; 1 = high.
- V_POLARITY, 0, same rule for vsync.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- pix_en  in  1  pixel tick; the counters advance only on clk edges where it is 1.
- h_count  out  CW  current pixel column.
- v_count  out  CW  current line.
- hsync  out  1  horizontal sync, polarity per H_POLARITY.
- vsync  out  1  vertical sync, polarity per V_POLARITY.
- de  out  1  display enable: 1 iff h_count < H_ACTIVE and v_count < V_ACTIVE.
- line_start  out  1  one-clk strobe on entry to h_count = 0.
- frame_start  out  1  one-clk strobe on entry to (0,0).

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the four H parameters; V_TOTAL likewise (800 / 525 at defaults).
  - H_SS = H_ACTIVE + H_FRONT_PORCH; H_SE = H_SS + H_SYNC_PULSE; V_SS and V_SE are formed the same way.
- Elaboration check (initial block, $error):
  - H_TOTAL and V_TOTAL must each be ≤ 2^CW.
  - Every parameter must be ≥ 1.
- Reset, taken on a clk edge with rst_n = 0, regardless of pix_en:
  - h_count = H_TOTAL-1, v_count = V_TOTAL-1.
  - hsync and vsync at their inactive level.
  - de = 0, line_start = 0, frame_start = 0.
  - Reset mid-frame aborts the frame immediately.
- Counting, on a clk edge with pix_en = 1:
  - h_count wraps from H_TOTAL-1 to 0; otherwise it increments.
  - v_count advances only when h_count wraps. It wraps from V_TOTAL-1 to 0; otherwise it increments.
  - With pix_en = 0, all counters and levels hold.
- Registered decode:
  - hsync, vsync and de are registered and computed from the next counter values, so they are always coherent with h_count and v_count in the same cycle (zero lag).
  - hsync is active iff H_SS ≤ h < H_SE.
  - vsync is active iff V_SS ≤ v < V_SE. vsync therefore changes only together with h_count = 0.
- Strobes:
  - line_start = 1 for exactly the one clk cycle following a pix_en edge that loads h = 0.
  - frame_start is the same, but for a load of (h = 0, v = 0).
  - Both are 0 on every other cycle, including while pix_en stays low.
- Latency: the first pix_en after reset release produces (0,0) with de = 1, line_start = 1 and frame_start = 1 in the next cycle.
- pix_en held permanently at 1 is legal (one pixel per clk).

Optional Feature:
- Macro: VGA_TIMING_LINE_MATCH_EN.
- Defined:
  - Adds input line_match [CW-1:0] and output line_irq [1].
  - line_irq is a one-clk strobe, coincident with line_start, when the new v_count equals line_match.
  - line_match is sampled on the same pix_en edge.
  - line_irq resets to 0.
  - If line_match ≥ V_TOTAL, line_irq never fires.
- Undefined: neither port exists, no logic is generated, and the rest of the behaviour is identical.

Decomposition:
- Package vga_timing_pkg:
  - typedef struct vga_axis_t {active, front_porch, sync_pulse, back_porch}.
  - Constants VGA_640x480_H / VGA_640x480_V and VGA_800x600_H / VGA_800x600_V.
  - Function axis_total().
- Sub-module vga_axis_counter, instantiated twice (h and v):
  - Parameters: CW, ACTIVE, FP, SYNC, BP, POLARITY.
  - Inputs: clk, rst_n, step. Outputs: count, sync, active, wrap.
  - The v instance has its step input driven by the h instance's wrap AND pix_en.

Test Plan:
- Reset then pix_en = 1 continuously → cycle 1: h = 0, v = 0, de = 1, frame_start = 1; h = 639 → de = 1; h = 640 → de = 0; each line is 800 clks and each frame is 420000 clks.
- Defaults, H_POLARITY = 0 → hsync = 0 exactly for h = 656..751 (96 clks) and 1 otherwise; vsync = 0 exactly for v = 490..491, with edges aligned to h = 0.
- H_POLARITY = 1, V_POLARITY = 1 → both syncs are inverted; at reset hsync = 0, vsync = 0.
- pix_en asserted every 4th clk → counters step once per 4 clks; line_start and frame_start are each 1 clk wide, never 4.
- rst_n = 0 for one cycle at (h = 300, v = 200) → next cycle h = 799, v = 524, de = 0; the next pix_en gives (0,0) with frame_start = 1.
- With VGA_TIMING_LINE_MATCH_EN, line_match = 100 → line_irq fires once per frame, coincident with line_start at v = 100; line_match = 600 → never fires.
